// File: rtl/serial_ripple_subtractor.sv
// Bit-serial a - b - bin, one bit per clock LSB first through a single full-subtractor cell.
// Latency WIDTH+1 cycles start-to-done; start is ignored while busy (no queueing, no backpressure).
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic             brw;
  logic             brw_next;
  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic [CW-1:0]    cnt;
  logic             last;

  always_comb begin
    a_bit         = a_q[cnt];
    b_bit         = b_q[cnt];
    d_bit         = a_bit ^ b_bit ^ brw;
    brw_next      = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw);
    res_next      = res_q;
    res_next[cnt] = d_bit;
    last          = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back operation
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            brw   <= bin;
            res_q <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          res_q <= res_next;
          brw   <= brw_next;
          if (last) begin
            diff  <= res_next;
            bout  <= brw_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed and swept checks of the bit-serial subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_ripple_subtractor;

  logic       clk;
  logic       rst;

  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  int checks;
  int failures;

  serial_ripple_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  serial_ripple_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation and returns negedges from the start drive to the done cycle (WIDTH+1 expected).
  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bi,
                     output int cyc, output logic [3:0] d, output logic bo);
    @(negedge clk);
    a4 = av; b4 = bv; bin4 = bi; start4 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start4 = 1'b0;
      cyc++;
    end while (!done4 && cyc < 30);
    d  = diff4;
    bo = bout4;
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                     output int cyc, output logic [7:0] d, output logic bo);
    @(negedge clk);
    a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      cyc++;
    end while (!done8 && cyc < 30);
    d  = diff8;
    bo = bout8;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b done=%b required busy=0 done=0", busy4, done4);
    end
    checks++;
    if (diff4 !== 4'h0 || bout4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: diff=%h bout=%b required diff=0 bout=0", diff4, bout4);
    end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_w8: busy=%b done=%b diff=%h bout=%b required all 0", busy8, done8, diff8, bout8);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd5; bin4 = 1'b0; start4 = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start4 = 1'b0;
      checks++;
      if (busy4 !== 1'b1 || done4 !== 1'b0) begin
        failures++;
        $display("FAIL basic_busy cycle %0d: busy=%b done=%b required busy=1 done=0", n, busy4, done4);
      end
    end
    @(negedge clk);
    checks++;
    if (done4 !== 1'b1 || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: done=%b busy=%b required done=1 busy=0", done4, busy4);
    end
    checks++;
    if (diff4 !== 4'd2 || bout4 !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: diff=%h bout=%b required diff=2 bout=0", diff4, bout4);
    end
    @(negedge clk);
    checks++;
    if (done4 !== 1'b0 || diff4 !== 4'd2) begin
      failures++;
      $display("FAIL basic_pulse_hold: done=%b diff=%h required done=0 diff=2", done4, diff4);
    end
  endtask

  task automatic test_vectors();
    logic [3:0] va[5] = '{4'd3, 4'd0, 4'hF, 4'h8, 4'h0};
    logic [3:0] vb[5] = '{4'd5, 4'd0, 4'hF, 4'h1, 4'h1};
    logic       vi[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] ed[5] = '{4'hE, 4'hF, 4'h0, 4'h6, 4'hF};
    logic       eb[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int         cyc;
    logic [3:0] d;
    logic       bo;
    for (int i = 0; i < 5; i++) begin
      op4(va[i], vb[i], vi[i], cyc, d, bo);
      checks++;
      if (cyc !== 5) begin
        failures++;
        $display("FAIL vec%0d_latency: cycles=%0d required 5", i, cyc);
      end
      checks++;
      if (d !== ed[i] || bo !== eb[i]) begin
        failures++;
        $display("FAIL vec%0d_result: diff=%h bout=%b required diff=%h bout=%b", i, d, bo, ed[i], eb[i]);
      end
    end
  endtask

  // Previous result is 0-1-0 = F with borrow; it must stay visible throughout this RUN.
  task automatic test_ignore_start();
    int n;
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd2; bin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    a4 = 4'd1; b4 = 4'hF; bin4 = 1'b0; start4 = 1'b1;
    checks++;
    if (diff4 !== 4'hF || bout4 !== 1'b1) begin
      failures++;
      $display("FAIL ignore_hold: diff=%h bout=%b required diff=F bout=1", diff4, bout4);
    end
    @(negedge clk);
    a4 = 4'h0; b4 = 4'h0; bin4 = 1'b1; start4 = 1'b0;
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h0; bin4 = 1'b0;
    n = 3;
    while (!done4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 5) begin
      failures++;
      $display("FAIL ignore_latency: cycles=%0d required 5", n);
    end
    checks++;
    if (diff4 !== 4'd6 || bout4 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result: diff=%h bout=%b required diff=6 bout=0", diff4, bout4);
    end
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_not_queued: busy=%b required 0", busy4);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va[4] = '{4'd7, 4'd3, 4'hC, 4'd1};
    logic [3:0] vb[4] = '{4'd5, 4'd5, 4'd3, 4'd2};
    logic       vi[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] ed[4] = '{4'd2, 4'hE, 4'd8, 4'hE};
    logic       eb[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int         n;
    @(negedge clk);
    a4 = va[0]; b4 = vb[0]; bin4 = vi[0]; start4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done4 && n < 30);
      checks++;
      if (n !== 5) begin
        failures++;
        $display("FAIL b2b%0d_spacing: cycles=%0d required 5", i, n);
      end
      checks++;
      if (diff4 !== ed[i] || bout4 !== eb[i]) begin
        failures++;
        $display("FAIL b2b%0d_result: diff=%h bout=%b required diff=%h bout=%b", i, diff4, bout4, ed[i], eb[i]);
      end
      if (i < 3) begin
        a4 = va[i+1]; b4 = vb[i+1]; bin4 = vi[i+1];
      end else begin
        start4 = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b done=%b required busy=0 done=0", busy4, done4);
    end
  endtask

  task automatic test_reset_mid_run();
    int         cyc;
    logic [3:0] d;
    logic       bo;
    logic       saw_done;
    @(negedge clk);
    a4 = 4'd0; b4 = 4'd1; bin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== 4'h0 || bout4 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear: busy=%b done=%b diff=%h bout=%b required all 0", busy4, done4, diff4, bout4);
    end
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done4 !== 1'b0 || diff4 !== 4'h0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_discard: partial result surfaced after reset, required none");
    end
    op4(4'd7, 4'd5, 1'b0, cyc, d, bo);
    checks++;
    if (cyc !== 5 || d !== 4'd2 || bo !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after: cycles=%0d diff=%h bout=%b required cycles=5 diff=2 bout=0", cyc, d, bo);
    end
  endtask

  task automatic test_sweep_w4();
    int         cyc;
    logic [3:0] d;
    logic       bo;
    logic [4:0] r;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          r = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - 5'(ic);
          op4(4'(ia), 4'(ib), 1'(ic), cyc, d, bo);
          checks++;
          if (cyc !== 5 || d !== r[3:0] || bo !== r[4]) begin
            failures++;
            $display("FAIL sweep4 %0d-%0d-%0d: cycles=%0d diff=%h bout=%b required cycles=5 diff=%h bout=%b",
                     ia, ib, ic, cyc, d, bo, r[3:0], r[4]);
          end
        end
      end
    end
  endtask

  task automatic test_sweep_w8();
    logic [7:0] vals[16] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h33, 8'h55, 8'h7E,
                             8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF};
    int         cyc;
    logic [7:0] d;
    logic       bo;
    logic [8:0] r;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          r = {1'b0, vals[ia]} - {1'b0, vals[ib]} - 9'(ic);
          op8(vals[ia], vals[ib], 1'(ic), cyc, d, bo);
          checks++;
          if (cyc !== 9 || d !== r[7:0] || bo !== r[8]) begin
            failures++;
            $display("FAIL sweep8 %h-%h-%0d: cycles=%0d diff=%h bout=%b required cycles=9 diff=%h bout=%b",
                     vals[ia], vals[ib], ic, cyc, d, bo, r[7:0], r[8]);
          end
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start4   = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8   = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep_w4();
    test_sweep_w8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
